// File: rtl/axi_arb_pkg.sv
// Shared widths, AR attribute field offsets and sizing helper for the AR arbiter.
package axi_arb_pkg;

    // Attribute packing, MSB to LSB: {cache,prot,lock,burst,size,len,qos,region}
    localparam int ATTR_W     = 29;
    localparam int REGION_LSB = 0;
    localparam int QOS_LSB    = 4;
    localparam int LEN_LSB    = 8;
    localparam int SIZE_LSB   = 16;
    localparam int BURST_LSB  = 19;
    localparam int LOCK_LSB   = 21;
    localparam int PROT_LSB   = 22;
    localparam int CACHE_LSB  = 25;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin grant among N requesters, search starts at the slot after the last grant.
// Latency: combinational grant; pointer advances on the clock after a grant.
// Backpressure: en_i low suppresses all grants and freezes the pointer.
module axi_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int  N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [SEL_W-1:0] gnt_idx_o
);

    logic [SEL_W-1:0] rr_ptr_q;
    logic [SEL_W-1:0] rr_ptr_d;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && en_i && req_i[(int'(rr_ptr_q) + i) % N]) begin
                found                              = 1'b1;
                gnt_idx_o                          = SEL_W'((int'(rr_ptr_q) + i) % N);
                gnt_o[(int'(rr_ptr_q) + i) % N]    = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (gnt_idx_o == SEL_W'(N - 1)) ? '0 : gnt_idx_o + SEL_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/axi_ar_arbiter.sv
// Shares one AXI AR channel among N requesters with per-requester outstanding-burst caps.
// Latency: 1 cycle from requester handshake to master_valid_o; one grant per cycle.
// Backpressure: a held output (valid & !ready) drops every slave_ready_o until it drains.
module axi_ar_arbiter
    import axi_arb_pkg::*;
#(
    parameter int  N_SLAVES        = 4,
    parameter int  ID_WIDTH        = 4,
    parameter int  ADDR_WIDTH      = 32,
    parameter int  USER_WIDTH      = 1,
    parameter int  MAX_OUTSTANDING = 8,
    localparam int SEL_W           = sel_width(N_SLAVES)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_SLAVES-1:0]            slave_valid_i,
    output logic [N_SLAVES-1:0]            slave_ready_o,
    input  logic [N_SLAVES*ADDR_WIDTH-1:0] slave_addr_i,
    input  logic [N_SLAVES*ATTR_W-1:0]     slave_attr_i,
    input  logic [N_SLAVES*ID_WIDTH-1:0]   slave_id_i,
    input  logic [N_SLAVES*USER_WIDTH-1:0] slave_user_i,
    output logic                           master_valid_o,
    output logic [ADDR_WIDTH-1:0]          master_addr_o,
    output logic [ATTR_W-1:0]              master_attr_o,
    output logic [ID_WIDTH+SEL_W-1:0]      master_id_o,
    output logic [USER_WIDTH-1:0]          master_user_o,
    input  logic                           master_ready_i,
    input  logic                           rdone_valid_i,
    input  logic [ID_WIDTH+SEL_W-1:0]      rdone_id_i,
    output logic [N_SLAVES-1:0]            slave_busy_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [N_SLAVES-1:0]     eligible;
    logic [N_SLAVES-1:0]     gnt;
    logic [N_SLAVES-1:0]     dec;
    logic [SEL_W-1:0]        gnt_idx;
    logic [SEL_W-1:0]        rdone_idx;
    logic                    accept_en;
    logic                    rdone_lsb_unused;
    logic [CNT_W-1:0]        cnt_q [N_SLAVES];
    logic [CNT_W-1:0]        cnt_d [N_SLAVES];

    logic                    master_valid_q;
    logic [ADDR_WIDTH-1:0]   master_addr_q;
    logic [ATTR_W-1:0]       master_attr_q;
    logic [ID_WIDTH+SEL_W-1:0] master_id_q;
    logic [USER_WIDTH-1:0]   master_user_q;

    assign accept_en        = ~master_valid_q | master_ready_i;
    assign rdone_idx        = rdone_id_i[ID_WIDTH +: SEL_W];
    // Only the index bits steer the counters; the requester's own ID is irrelevant here.
    assign rdone_lsb_unused = ^rdone_id_i[ID_WIDTH-1:0];

    always_comb begin
        for (int k = 0; k < N_SLAVES; k++) begin
            eligible[k]     = slave_valid_i[k] && (cnt_q[k] < CNT_W'(MAX_OUTSTANDING));
            dec[k]          = rdone_valid_i && (int'(rdone_idx) == k) && (cnt_q[k] != '0);
            slave_busy_o[k] = (cnt_q[k] != '0);
        end
    end

    axi_rr_arbiter #(
        .N (N_SLAVES)
    ) u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (eligible),
        .en_i      (accept_en & ~rst_i),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign slave_ready_o = gnt;

    always_comb begin
        for (int k = 0; k < N_SLAVES; k++) begin
            unique case ({gnt[k], dec[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CNT_W'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CNT_W'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_SLAVES; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_SLAVES; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // A grant can only occur when the output slot is free or draining this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            master_valid_q <= 1'b0;
            master_addr_q  <= '0;
            master_attr_q  <= '0;
            master_id_q    <= '0;
            master_user_q  <= '0;
        end else if (|gnt) begin
            master_valid_q <= 1'b1;
            master_addr_q  <= slave_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            master_attr_q  <= slave_attr_i[int'(gnt_idx)*ATTR_W +: ATTR_W];
            master_id_q    <= {gnt_idx, slave_id_i[int'(gnt_idx)*ID_WIDTH +: ID_WIDTH]};
            master_user_q  <= slave_user_i[int'(gnt_idx)*USER_WIDTH +: USER_WIDTH];
        end else if (master_ready_i) begin
            master_valid_q <= 1'b0;
        end
    end

    assign master_valid_o = master_valid_q;
    assign master_addr_o  = master_addr_q;
    assign master_attr_o  = master_attr_q;
    assign master_id_o    = master_id_q;
    assign master_user_o  = master_user_q;

endmodule
